// File: rtl/hash_msg_chainer.sv
// Byte-stream front end for the 32-bit hash core: packs bytes into 4-byte blocks, pads, chains IVs.
// Define HASH_CHAIN_LEN_EN to append the message length byte to the final block.
module hash_msg_chainer (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    input  logic            in_last,
    input  logic [0:3][7:0] iv_init,
    output logic            core_start,
    output logic [0:3][7:0] core_m,
    output logic [0:3][7:0] core_iv,
    input  logic [0:3][7:0] core_d,
    input  logic            core_done,
    output logic            dig_valid,
    input  logic            dig_ready,
    output logic [0:3][7:0] dig,
    output logic            busy
);

    typedef enum logic [1:0] {COLLECT, START, WAIT, OUT} state_t;

    state_t          r_state, w_state_nxt;
    logic [0:3][7:0] r_m, r_iv, r_dig;
    logic [1:0]      r_bcnt;
    logic [7:0]      r_len;
    logic            r_final, r_pad_pend, r_pad80, r_inmsg;
    logic [7:0]      w_len_nxt;
    logic [7:0]      w_pad_len;
    logic [31:0]     w_k;
    logic            w_accept;

    assign core_m    = r_m;
    assign core_iv   = r_iv;
    assign dig       = r_dig;
    assign w_accept  = in_valid && (r_state == COLLECT);
    assign w_len_nxt = r_inmsg ? r_len + 8'd1 : 8'd1;
    assign w_k       = 32'(r_bcnt);
    assign busy      = !((r_state == COLLECT) && (r_bcnt == 2'd0) && !r_inmsg);
`ifdef HASH_CHAIN_LEN_EN
    assign w_pad_len = r_len;
`else
    assign w_pad_len = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= COLLECT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        core_start  = 1'b0;
        dig_valid   = 1'b0;
        case (r_state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || r_bcnt == 2'd3)) w_state_nxt = START;
            end
            START: begin
                core_start  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    if (r_final)         w_state_nxt = OUT;
                    else if (r_pad_pend) w_state_nxt = START;
                    else                 w_state_nxt = COLLECT;
                end
            end
            OUT: begin
                dig_valid = 1'b1;
                if (dig_ready) w_state_nxt = COLLECT;
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m        <= '0;
            r_iv       <= '0;
            r_dig      <= '0;
            r_bcnt     <= '0;
            r_len      <= '0;
            r_final    <= 1'b0;
            r_pad_pend <= 1'b0;
            r_pad80    <= 1'b0;
            r_inmsg    <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: if (w_accept) begin
                    if (!r_inmsg) r_iv <= iv_init;
                    r_inmsg <= 1'b1;
                    r_len   <= w_len_nxt;
                    r_bcnt  <= r_bcnt + 2'd1;
                    r_final    <= 1'b0;
                    r_pad_pend <= 1'b0;
                    if (in_last) begin
                        // 10* fill of the tail bytes; length byte (if enabled) overrides byte 3 afterwards
                        for (int unsigned j = 0; j < 4; j++)
                            if (j > w_k) r_m[j[1:0]] <= (j == w_k + 32'd1) ? 8'h80 : 8'h00;
`ifdef HASH_CHAIN_LEN_EN
                        if (r_bcnt <= 2'd1) begin
                            r_m[3]  <= w_len_nxt;
                            r_final <= 1'b1;
                        end else if (r_bcnt == 2'd2) begin
                            r_m[3]     <= 8'h80;
                            r_pad_pend <= 1'b1;
                            r_pad80    <= 1'b0;
                        end else begin
                            r_pad_pend <= 1'b1;
                            r_pad80    <= 1'b1;
                        end
`else
                        if (r_bcnt != 2'd3) begin
                            r_final <= 1'b1;
                        end else begin
                            r_pad_pend <= 1'b1;
                            r_pad80    <= 1'b1;
                        end
`endif
                    end
                    r_m[r_bcnt] <= in_data;
                end
                WAIT: if (core_done) begin
                    if (r_final) begin
                        r_dig <= core_d;
                    end else if (r_pad_pend) begin
                        r_iv       <= core_d;
                        r_m        <= {(r_pad80 ? 8'h80 : 8'h00), 8'h00, 8'h00, w_pad_len};
                        r_pad_pend <= 1'b0;
                        r_final    <= 1'b1;
                    end else begin
                        r_iv   <= core_d;
                        r_bcnt <= '0;
                    end
                end
                OUT: if (dig_ready) begin
                    r_len   <= '0;
                    r_bcnt  <= '0;
                    r_inmsg <= 1'b0;
                    r_final <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_msg_chainer.sv
// Directed bench for hash_msg_chainer with a core stub (done 27 cycles after start, d = m ^ iv).
// Expected values switch with HASH_CHAIN_LEN_EN.
module tb_hash_msg_chainer;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_last;
    logic [7:0]      in_data;
    logic [0:3][7:0] iv_init;
    logic            core_start, core_done;
    logic [0:3][7:0] core_m, core_iv, core_d;
    logic            dig_valid, dig_ready, busy;
    logic [0:3][7:0] dig;

    int          nvec = 0;
    int          nerr = 0;
    int          nstart = 0;
    int          stub_cnt = 0;
    logic [31:0] log_m  [0:31];
    logic [31:0] log_iv [0:31];

`ifdef HASH_CHAIN_LEN_EN
    localparam logic [31:0] E1_DIG = 32'hABB9CF87, E2_PADM = 32'h80000004, E2_DIG = 32'h91223340;
    localparam logic [31:0] E9_M3 = 32'h09800009, E9_DIG = 32'hFD74F4F5, E5A_M = 32'h5A800001;
    localparam int          E1_N = 2;
`else
    localparam logic [31:0] E1_DIG = 32'hABB9CF84, E2_PADM = 32'h80000000, E2_DIG = 32'h91223344;
    localparam logic [31:0] E9_M3 = 32'h09800000, E9_DIG = 32'hFD74F4FC, E5A_M = 32'h5A800000;
    localparam int          E1_N = 1;
`endif

    hash_msg_chainer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .iv_init(iv_init),
        .core_start(core_start), .core_m(core_m), .core_iv(core_iv),
        .core_d(core_d), .core_done(core_done),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig(dig), .busy(busy)
    );

    always #5 clk = ~clk;

    // Core stub is deliberately not reset so a stale done can arrive after a DUT reset.
    initial begin
        core_done = 1'b0;
        core_d    = '0;
    end
    always @(negedge clk) begin
        core_done = 1'b0;
        if (core_start) begin
            if (nstart < 32) begin
                log_m[nstart]  = core_m;
                log_iv[nstart] = core_iv;
            end
            nstart++;
            stub_cnt = 27;
        end else if (stub_cnt != 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                core_done = 1'b1;
                core_d    = core_m ^ core_iv;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 200) begin step(1); n++; end
        if (!in_ready) chk(tag, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        wait_ready("in_ready_timeout");
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_dig(input string tag);
        int n = 0;
        while (!dig_valid && n < 300) begin step(1); n++; end
        chk(tag, {31'd0, dig_valid}, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd1);
        chk({tag, "_core_start"}, {31'd0, core_start}, 32'd0);
        chk({tag, "_dig_valid"},  {31'd0, dig_valid},  32'd0);
        chk({tag, "_busy"},       {31'd0, busy},       32'd0);
        chk({tag, "_core_m"},     core_m,  32'd0);
        chk({tag, "_core_iv"},    core_iv, 32'd0);
        chk({tag, "_dig"},        dig,     32'd0);
    endtask

    initial begin
        int s0;
        logic [31:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        iv_init = '0; dig_ready = 1'b1;
        step(3);
        check_reset("rst0");
        rst_n = 1'b1;
        step(2);

        // 3-byte message; iv_init changed after the first byte must not be used
        s0 = nstart;
        iv_init = 32'h01020304;
        send_byte(8'hAA, 1'b0);
        iv_init = 32'hFFFFFFFF;
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        chk("m3_busy", {31'd0, busy}, 32'd1);
        wait_dig("m3_dig_valid");
        chk("m3_dig", dig, E1_DIG);
        chk("m3_starts", nstart - s0, E1_N);
        chk("m3_blk0_m", log_m[s0], 32'hAABBCC80);
        chk("m3_blk0_iv", log_iv[s0], 32'h01020304);
        step(1);
        chk("m3_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("m3_busy_after", {31'd0, busy}, 32'd0);

        // 4-byte message plus backpressure on the digest
        s0 = nstart;
        dig_ready = 1'b0;
        iv_init = '0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_dig("m4_dig_valid");
        chk("m4_starts", nstart - s0, 2);
        chk("m4_pad_m", log_m[s0 + 1], E2_PADM);
        chk("m4_pad_iv", log_iv[s0 + 1], 32'h11223344);
        chk("m4_dig", dig, E2_DIG);
        held = dig;
        s0 = nstart;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("bp_dig_stable", dig, held);
            chk("bp_dig_valid", {31'd0, dig_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        chk("bp_no_start", nstart - s0, 0);
        dig_ready = 1'b1;
        step(1);
        chk("bp_accept_valid", {31'd0, dig_valid}, 32'd0);
        chk("bp_accept_ready", {31'd0, in_ready}, 32'd1);

        // 9-byte message: three chained blocks
        s0 = nstart;
        iv_init = 32'hF0F0F0F0;
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(i + 1), i == 8);
            if (i == 3) begin
                wait_ready("m9_ready_timeout");
                chk("m9_busy_midmsg", {31'd0, busy}, 32'd1);
            end
        end
        wait_dig("m9_dig_valid");
        chk("m9_starts", nstart - s0, 3);
        chk("m9_iv0", log_iv[s0], 32'hF0F0F0F0);
        chk("m9_iv1", log_iv[s0 + 1], 32'hF1F2F3F4);
        chk("m9_iv2", log_iv[s0 + 2], 32'hF4F4F4FC);
        chk("m9_m1", log_m[s0 + 1], 32'h05060708);
        chk("m9_m2", log_m[s0 + 2], E9_M3);
        chk("m9_dig", dig, E9_DIG);
        step(1);

`ifdef HASH_CHAIN_LEN_EN
        // 2-byte message with length byte
        iv_init = '0;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b1);
        wait_dig("len2_dig_valid");
        chk("len2_last_byte3", {24'd0, log_m[nstart - 1][7:0]}, 32'h02);
        chk("len2_dig", dig, 32'h12348002);
        step(1);
`endif

        // reset while waiting on the core; the stale done must be ignored
        iv_init = 32'h0A0B0C0D;
        send_byte(8'h77, 1'b1);
        step(6);
        rst_n = 1'b0;
        #1;
        check_reset("rstw");
        step(2);
        rst_n = 1'b1;
        step(30);
        chk("stale_dig_valid", {31'd0, dig_valid}, 32'd0);
        chk("stale_busy", {31'd0, busy}, 32'd0);
        chk("stale_in_ready", {31'd0, in_ready}, 32'd1);
        s0 = nstart;
        iv_init = '0;
        send_byte(8'h5A, 1'b1);
        wait_dig("m1_dig_valid");
        chk("m1_starts", nstart - s0, 1);
        chk("m1_m", log_m[s0], E5A_M);
        chk("m1_dig", dig, E5A_M);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
